// File: rtl/mcs4_pkg.sv
// rtl/mcs4_pkg.sv - shared MCS-4 ROM arbiter constants and state encoding
package mcs4_pkg;

    localparam int MCS4_ROM_ADDR_W = 12;
    localparam int MCS4_ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_WAIT  = 2'd1,
        HOST_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mcs4_rom_arb_stats.sv
// rtl/mcs4_rom_arb_stats.sv - saturating issue counters and longest host wait
// Instantiated by the arbiter only when MCS4_ROM_ARB_STATS_EN is defined.
module mcs4_rom_arb_stats (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cpu_issue,
    input  logic        host_issue,
    input  logic        host_req,
    output logic [15:0] stat_cpu_fetch,
    output logic [15:0] stat_host_read,
    output logic [7:0]  stat_host_wmax
);

    logic [7:0] wait_cnt;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            stat_cpu_fetch <= '0;
            stat_host_read <= '0;
            stat_host_wmax <= '0;
            wait_cnt       <= '0;
        end else begin
            if (cpu_issue && stat_cpu_fetch != 16'hFFFF)
                stat_cpu_fetch <= stat_cpu_fetch + 16'd1;
            if (host_issue && stat_host_read != 16'hFFFF)
                stat_host_read <= stat_host_read + 16'd1;
            // wait_cnt counts edges the request was held without being granted
            if (host_issue) begin
                if (wait_cnt > stat_host_wmax)
                    stat_host_wmax <= wait_cnt;
                wait_cnt <= '0;
            end else if (host_req) begin
                if (wait_cnt != 8'hFF)
                    wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mcs4_rom_arbiter.sv
// rtl/mcs4_rom_arbiter.sv - i4001 fetch / host read arbiter for one ROM store
// Optional statistics outputs under MCS4_ROM_ARB_STATS_EN.
module mcs4_rom_arbiter
    import mcs4_pkg::*;
#(
    parameter int ADDR_W      = MCS4_ROM_ADDR_W,
    parameter int DATA_W      = MCS4_ROM_DATA_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
`ifdef MCS4_ROM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_fetch,
    output logic [15:0]       stat_host_read,
    output logic [7:0]        stat_host_wmax
`endif
);

    localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] tag;
    logic              tag_valid;
    logic              cpu_pend;
    logic              cpu_issue;
    logic              host_issue;

    // The CPU always wins an idle slot; the host only gets slots where the tag matches.
    assign cpu_pend   = !tag_valid || (cpu_addr != tag);
    assign cpu_issue  = (state == IDLE) && cpu_pend;
    assign host_issue = (state == IDLE) && !cpu_pend && host_req;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tag         <= '0;
            tag_valid   <= 1'b0;
            mem_addr    <= '0;
            cpu_data    <= '0;
            host_rdata  <= '0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_issue) begin
                        mem_addr  <= cpu_addr;
                        tag       <= cpu_addr;
                        tag_valid <= 1'b1;
                        cnt       <= CNT_W'(MEM_LATENCY);
                        state     <= CPU_WAIT;
                    end else if (host_issue) begin
                        mem_addr <= host_addr;
                        host_gnt <= 1'b1;
                        cnt      <= CNT_W'(MEM_LATENCY);
                        state    <= HOST_WAIT;
                    end
                end
                CPU_WAIT: begin
                    // A stale word lands here if cpu_addr moved; the tag mismatch refetches.
                    if (cnt == '0) begin
                        cpu_data <= mem_data;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOST_WAIT: begin
                    if (cnt == '0) begin
                        host_rdata  <= mem_data;
                        host_rvalid <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MCS4_ROM_ARB_STATS_EN
    mcs4_rom_arb_stats u_stats (
        .sysclk         (sysclk),
        .reset          (reset),
        .cpu_issue      (cpu_issue),
        .host_issue     (host_issue),
        .host_req       (host_req),
        .stat_cpu_fetch (stat_cpu_fetch),
        .stat_host_read (stat_host_read),
        .stat_host_wmax (stat_host_wmax)
    );
`endif

endmodule

// File: tb/tb_mcs4_rom_arbiter.sv
// tb/tb_mcs4_rom_arbiter.sv - directed self-checking bench for mcs4_rom_arbiter
module tb_mcs4_rom_arbiter;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        host_req;
    logic [11:0] host_addr;
    logic        host_gnt;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
`ifdef MCS4_ROM_ARB_STATS_EN
    logic [15:0] stat_cpu_fetch;
    logic [15:0] stat_host_read;
    logic [7:0]  stat_host_wmax;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mcs4_rom_arbiter #(.ADDR_W(12), .DATA_W(8), .MEM_LATENCY(1)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data)
`ifdef MCS4_ROM_ARB_STATS_EN
        ,
        .stat_cpu_fetch (stat_cpu_fetch),
        .stat_host_read (stat_host_read),
        .stat_host_wmax (stat_host_wmax)
`endif
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    // ROM contents: store[000]=D5, store[0FF]=D4
    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return (a[7:0] ^ {a[11:8], a[11:8]}) + 8'hD5;
    endfunction

    // One-cycle registered store
    always @(posedge sysclk) mem_data <= rom_f(mem_addr);

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int gcyc;
        int prev_gcyc;
        int t0;
        logic seen;

        reset = 1'b1; cpu_addr = 12'h000; host_req = 1'b0; host_addr = 12'h000;
        step(); step(); step();
        chk("rst_cpu_data", {8'h0, cpu_data}, 16'h0);
        chk("rst_host_rdata", {8'h0, host_rdata}, 16'h0);
        chk("rst_gnt", {15'h0, host_gnt}, 16'h0);
        chk("rst_rvalid", {15'h0, host_rvalid}, 16'h0);
        chk("rst_mem_addr", {4'h0, mem_addr}, 16'h0);

        // 1: first fetch after reset release
        reset = 1'b0;
        step();
        chk("t1_mem_addr_e1", {4'h0, mem_addr}, 16'h000);
        step();
        chk("t1_cpu_data_e2", {8'h0, cpu_data}, 16'h00);
        step();
        chk("t1_cpu_data_e3", {8'h0, cpu_data}, 16'h00D5);

        // 2: CPU change and host request together, CPU first
        cpu_addr = 12'h001; host_req = 1'b1; host_addr = 12'h0FF;
        step();
        chk("t2_cpu_issue", {4'h0, mem_addr}, 16'h001);
        chk("t2_no_gnt_a", {15'h0, host_gnt}, 16'h0);
        step();
        chk("t2_no_gnt_b", {15'h0, host_gnt}, 16'h0);
        step();
        chk("t2_cpu_data", {8'h0, cpu_data}, {8'h0, rom_f(12'h001)});
        chk("t2_no_gnt_c", {15'h0, host_gnt}, 16'h0);
        step();
        chk("t2_gnt", {15'h0, host_gnt}, 16'h1);
        chk("t2_host_addr", {4'h0, mem_addr}, 16'h0FF);
        host_req = 1'b0;
        step();
        chk("t2_gnt_pulse", {15'h0, host_gnt}, 16'h0);
        chk("t2_rvalid_early", {15'h0, host_rvalid}, 16'h0);
        step();
        chk("t2_rvalid", {15'h0, host_rvalid}, 16'h1);
        chk("t2_rdata", {8'h0, host_rdata}, 16'h00D4);

        // 3: cpu_addr moves during CPU_WAIT
        cpu_addr = 12'h123;
        step();
        chk("t3_issue_a", {4'h0, mem_addr}, 16'h123);
        chk("t3_rvalid_pulse", {15'h0, host_rvalid}, 16'h0);
        cpu_addr = 12'h456;
        step();
        step();
        chk("t3_stale", {8'h0, cpu_data}, {8'h0, rom_f(12'h123)});
        step();
        chk("t3_reissue", {4'h0, mem_addr}, 16'h456);
        step();
        step();
        chk("t3_final", {8'h0, cpu_data}, {8'h0, rom_f(12'h456)});

        // 4: ten back-to-back host reads, cpu_addr static
        prev_gcyc = 0;
        for (int i = 0; i < 10; i++) begin
            host_req  = 1'b1;
            host_addr = 12'h200 + 12'(i);
            step();
            for (int n = 0; n < 8 && !host_gnt; n++) step();
            chk("t4_gnt", {15'h0, host_gnt}, 16'h1);
            chk("t4_mem_addr", {4'h0, mem_addr}, {4'h0, 12'h200 + 12'(i)});
            gcyc = cyc;
            if (i > 0) chk("t4_gnt_spacing", 16'(gcyc - prev_gcyc), 16'd3);
            prev_gcyc = gcyc;
            if (i == 9) host_req = 1'b0;
            else host_addr = 12'h200 + 12'(i + 1);
            step();
            for (int n = 0; n < 8 && !host_rvalid; n++) step();
            chk("t4_rvalid", {15'h0, host_rvalid}, 16'h1);
            chk("t4_rvalid_lat", 16'(cyc - gcyc), 16'd2);
            chk("t4_rdata", {8'h0, host_rdata}, {8'h0, rom_f(12'h200 + 12'(i))});
        end

        // 5: reset while HOST_WAIT
        host_req = 1'b1; host_addr = 12'h300;
        step();
        chk("t5_gnt", {15'h0, host_gnt}, 16'h1);
        host_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("t5_rvalid", {15'h0, host_rvalid}, 16'h0);
        chk("t5_rdata", {8'h0, host_rdata}, 16'h0);
        chk("t5_cpu_data", {8'h0, cpu_data}, 16'h0);
        chk("t5_mem_addr", {4'h0, mem_addr}, 16'h0);
        chk("t5_gnt_rst", {15'h0, host_gnt}, 16'h0);
        step();
        chk("t5_rvalid_b", {15'h0, host_rvalid}, 16'h0);
        reset = 1'b0;
        step();
        chk("t5_refetch", {4'h0, mem_addr}, 16'h456);
        step();
        step();
        chk("t5_refetch_data", {8'h0, cpu_data}, {8'h0, rom_f(12'h456)});

        // host request abandoned before grant
        cpu_addr = 12'h0A0; host_req = 1'b1; host_addr = 12'h0B0;
        step();
        step();
        host_req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            seen = seen | host_gnt | host_rvalid;
        end
        chk("ab_no_gnt_rvalid", {15'h0, seen}, 16'h0);
        chk("ab_cpu_data", {8'h0, cpu_data}, {8'h0, rom_f(12'h0A0)});

        // host stalled 3 cycles behind a CPU fetch
        cpu_addr = 12'h0C0; host_req = 1'b1; host_addr = 12'h0D0;
        t0 = cyc;
        step();
        for (int n = 0; n < 8 && !host_gnt; n++) step();
        chk("st_gnt", {15'h0, host_gnt}, 16'h1);
        chk("st_gnt_delay", 16'(cyc - t0), 16'd4);
        host_req = 1'b0;
        step();
        step();
        chk("st_rdata", {8'h0, host_rdata}, {8'h0, rom_f(12'h0D0)});
`ifdef MCS4_ROM_ARB_STATS_EN
        chk("stat_cpu_fetch", stat_cpu_fetch, 16'd3);
        chk("stat_host_read", stat_host_read, 16'd1);
        chk("stat_host_wmax", {8'h0, stat_host_wmax}, 16'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
